nes_pad_reader: RTL

- Serial controller that sequences two external NES pads (4021-style shift registers) through a shared latch/clock pair.
- Delivers debounce-free parallel 8-bit button arrays in the NES joypad format, plus a change strobe for the $4016/$4017 MMR logic.
- Replaces the parallel button array plus debouncers when real controllers are plugged into the board.

---
 rtl/nes_pad_reader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/nes_pad_reader.sv
`default_nettype none
// ============================================================================
// Module  : nes_pad_reader
// Brief   : Scans two 4021-style NES pads over a shared latch/clock pair and
//           presents parallel 8-bit button arrays plus a change strobe.
// Revision: 1.0
// ============================================================================
module nes_pad_reader #(
  parameter int CLK_DIV     = 300,
  parameter int POLL_PERIOD = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       poll_req,
  input  logic       pad_data1,
  input  logic       pad_data2,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] joypad1,
  output logic [7:0] joypad2,
  output logic       btn_strobe,
  output logic       busy
);

  localparam int TW = $clog2(POLL_PERIOD);
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_PERIOD - 1);
  localparam logic [DW-1:0] LATCH_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] HALF_LAST  = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    CLK_HI = 3'd2,
    CLK_LO = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [7:0]    shift1;
  logic [7:0]    shift2;
  logic          tick;
  logic          start;
  logic          sample1;
  logic          sample2;
  logic [7:0]    next1;
  logic [7:0]    next2;

  // Pad lines are active-low and asynchronous; synchronizers idle high (released).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= {sync1[0], pad_data1};
      sync2 <= {sync2[0], pad_data2};
    end
  end

  assign sample1 = ~sync1[1];
  assign sample2 = ~sync2[1];

  always_ff @(posedge clk) begin
    if (reset || tick) timer <= '0;
    else               timer <= timer + 1'b1;
  end

  assign tick  = (timer == TIMER_LAST);
  assign start = (tick && en) || poll_req;

  // Final bit arrives on the last CLK_LO cycle, so the new arrays are assembled here.
  always_comb begin
    next1    = shift1;
    next2    = shift2;
    next1[7] = sample1;
    next2[7] = sample2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_idx    <= 3'd0;
      shift1     <= 8'h00;
      shift2     <= 8'h00;
      pad_latch  <= 1'b0;
      pad_clk    <= 1'b0;
      joypad1    <= 8'h00;
      joypad2    <= 8'h00;
      btn_strobe <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LATCH;
            div_cnt   <= '0;
            pad_latch <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LATCH: begin
          if (div_cnt == LATCH_LAST) begin
            shift1[0] <= sample1;
            shift2[0] <= sample2;
            bit_idx   <= 3'd1;
            div_cnt   <= '0;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b1;
            state     <= CLK_HI;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        CLK_HI: begin
          if (div_cnt == HALF_LAST) begin
            div_cnt <= '0;
            pad_clk <= 1'b0;
            state   <= CLK_LO;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        CLK_LO: begin
          if (div_cnt == HALF_LAST) begin
            shift1[bit_idx] <= sample1;
            shift2[bit_idx] <= sample2;
            div_cnt         <= '0;
            if (bit_idx == 3'd7) begin
              joypad1    <= next1;
              joypad2    <= next2;
              btn_strobe <= (next1 != joypad1) || (next2 != joypad2);
              state      <= DONE;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              pad_clk <= 1'b1;
              state   <= CLK_HI;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          btn_strobe <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state      <= IDLE;
          pad_latch  <= 1'b0;
          pad_clk    <= 1'b0;
          btn_strobe <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
